// File: rtl/mul_pkg.sv
// Shared definitions for the HI/LO multiply-divide unit: mulop encodings and default latencies.
package mul_pkg;

    localparam logic [1:0] MULOP_SIGNED   = 2'b00;
    localparam logic [1:0] MULOP_UNSIGNED = 2'b01;
    localparam logic [1:0] MULOP_MTHI     = 2'b10;
    localparam logic [1:0] MULOP_MTLO     = 2'b11;

    localparam int MUL_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mul.sv
// HI/LO multiply-divide unit: fixed-latency multiply/divide on latched operands, plus mthi/mtlo.
// The result is computed combinationally from the latched operands and committed when the counter expires.
module mul
    import mul_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] ind1,
    input  logic [WIDTH-1:0] ind2,
    input  logic [1:0]       mulop,
    input  logic             m,
    input  logic             d,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_uns;
    logic             op_div;
    logic [CW-1:0]    count;

    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   safe_b;
    logic [WIDTH-1:0]   q_mag;
    logic [WIDTH-1:0]   r_mag;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic               div_zero;

    // Low 2W bits of the product are the same for signed and unsigned once operands are extended.
    always_comb begin
        ext_a = op_uns ? {{WIDTH{1'b0}}, op_a} : {{WIDTH{op_a[WIDTH-1]}}, op_a};
        ext_b = op_uns ? {{WIDTH{1'b0}}, op_b} : {{WIDTH{op_b[WIDTH-1]}}, op_b};
        prod  = ext_a * ext_b;
    end

    // Divide on magnitudes so MIN / -1 wraps to MIN instead of overflowing.
    always_comb begin
        neg_a    = !op_uns && op_a[WIDTH-1];
        neg_b    = !op_uns && op_b[WIDTH-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        safe_b   = div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : mag_b;
        q_mag    = mag_a / safe_b;
        r_mag    = mag_a % safe_b;
        quot     = (neg_a ^ neg_b) ? -q_mag : q_mag;
        rem      = neg_a ? -r_mag : r_mag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            count  <= '0;
            op_a   <= '0;
            op_b   <= '0;
            op_uns <= 1'b0;
            op_div <= 1'b0;
        end else if (busy) begin
            if (count == CW'(1)) begin
                busy  <= 1'b0;
                count <= '0;
                if (op_div) begin
                    if (!div_zero) begin
                        hi <= rem;
                        lo <= quot;
                    end
                end else begin
                    hi <= prod[2*WIDTH-1:WIDTH];
                    lo <= prod[WIDTH-1:0];
                end
            end else begin
                count <= count - CW'(1);
            end
        end else if (m || d) begin
            op_a   <= ind1;
            op_b   <= ind2;
            op_uns <= mulop[0];
            op_div <= !m;
            count  <= m ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
            busy   <= 1'b1;
        end else if (mulop == MULOP_MTHI) begin
            hi <= ind1;
        end else if (mulop == MULOP_MTLO) begin
            lo <= ind1;
        end
    end

endmodule

// File: tb/tb_mul.sv
// Self-checking bench for mul: directed cases plus randomized operations against an arithmetic model.
module tb_mul;
    import mul_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ind1 = '0;
    logic [31:0] ind2 = '0;
    logic [1:0]  mulop = 2'b00;
    logic        m = 1'b0;
    logic        d = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mul #(.WIDTH(32), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .ind1(ind1), .ind2(ind2), .mulop(mulop),
        .m(m), .d(d), .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
    function automatic void model(input bit is_div, input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, inout logic [31:0] h, inout logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        if (!is_div) begin
            if (op[0]) p = {32'b0, a} * {32'b0, b};
            else begin
                sa = $signed(a);
                sb = $signed(b);
                p  = sa * sb;
            end
            h = p[63:32];
            l = p[31:0];
        end else if (b != 0) begin
            if (op[0]) begin
                l = a / b;
                h = a % b;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
                l  = q[31:0];
                h  = r[31:0];
            end
        end
    endfunction

    // Start an op, stir random strobes/data while busy (must be ignored), then check the commit.
    task automatic run_op(input bit is_div, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = is_div ? DIV_LAT : MUL_LAT;
        ind1 = a; ind2 = b; mulop = op; m = !is_div; d = is_div;
        tick();
        for (int i = 0; i < lat; i++) begin
            check("busy_during", {31'b0, busy}, 32'd1);
            check("hi_hold", hi, exp_hi);
            check("lo_hold", lo, exp_lo);
            m = 1'($urandom); d = 1'($urandom); mulop = 2'($urandom);
            ind1 = $urandom; ind2 = $urandom;
            tick();
        end
        m = 1'b0; d = 1'b0; mulop = MULOP_SIGNED;
        model(is_div, op, a, b, exp_hi, exp_lo);
        check("busy_done", {31'b0, busy}, 32'd0);
        check("hi_result", hi, exp_hi);
        check("lo_result", lo, exp_lo);
    endtask

    task automatic move_to(input logic [1:0] op, input logic [31:0] a);
        ind1 = a; mulop = op; m = 1'b0; d = 1'b0;
        tick();
        mulop = MULOP_SIGNED;
        if (op == MULOP_MTHI) exp_hi = a;
        else exp_lo = a;
        check("mt_busy", {31'b0, busy}, 32'd0);
        check("mt_hi", hi, exp_hi);
        check("mt_lo", lo, exp_lo);
    endtask

    initial begin
        logic [31:0] a, b;
        int kind;

        #12;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_op(1'b0, MULOP_SIGNED, 32'hFFFF_FFFD, 32'd5);
        check("t1_hi", hi, 32'hFFFF_FFFF);
        check("t1_lo", lo, 32'hFFFF_FFF1);
        run_op(1'b0, MULOP_UNSIGNED, 32'hFFFF_FFFD, 32'd5);
        check("t2_hi", hi, 32'h0000_0004);
        check("t2_lo", lo, 32'hFFFF_FFF1);
        run_op(1'b1, MULOP_SIGNED, 32'hFFFF_FFF9, 32'd2);
        check("t3_hi", hi, 32'hFFFF_FFFF);
        check("t3_lo", lo, 32'hFFFF_FFFD);
        run_op(1'b1, MULOP_SIGNED, 32'd7, 32'd0);
        check("t3_dz_hi", hi, 32'hFFFF_FFFF);
        check("t3_dz_lo", lo, 32'hFFFF_FFFD);
        run_op(1'b1, MULOP_SIGNED, 32'h8000_0000, 32'hFFFF_FFFF);
        check("ovf_hi", hi, 32'h0);
        check("ovf_lo", lo, 32'h8000_0000);
        move_to(MULOP_MTHI, 32'h1234_5678);
        move_to(MULOP_MTLO, 32'hCAFE_BABE);
        run_op(1'b0, MULOP_UNSIGNED + 2'b10, 32'h0001_0000, 32'h0003_0000);
        check("t5_hi", hi, 32'h0000_0003);
        check("t5_lo", lo, 32'h0);

        // Reset in the middle of a divide: immediate clear, no late commit.
        ind1 = 32'd100; ind2 = 32'd7; mulop = MULOP_SIGNED; d = 1'b1;
        tick();
        d = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        exp_hi = '0; exp_lo = '0;
        check("t6_hi", hi, 32'h0);
        check("t6_lo", lo, 32'h0);
        check("t6_busy", {31'b0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < DIV_LAT + 2; i++) tick();
        check("t6_late_hi", hi, 32'h0);
        check("t6_late_lo", lo, 32'h0);
        check("t6_late_busy", {31'b0, busy}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 4);
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = $urandom_range(0, 20);
            case (kind)
                0: run_op(1'b0, 2'($urandom), a, b);
                1: run_op(1'b1, 2'($urandom), a, b);
                2: move_to(MULOP_MTHI, a);
                3: move_to(MULOP_MTLO, a);
                default: run_op(1'b1, MULOP_SIGNED, $urandom_range(0, 1) ? 32'h8000_0000 : a,
                                $urandom_range(0, 1) ? 32'hFFFF_FFFF : 32'h0);
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
